// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the two-master memory arbiter.
// Holds the memory-port field widths, the master index type and the request bundle
// that the arbiter muxes onto the downstream port.
package mem_arbiter2_pkg;

  // Memory-port field widths shared with the masters and sram16_ctrl.
  localparam int unsigned IdW   = 2;
  localparam int unsigned AddrW = 30;
  localparam int unsigned DataW = 32;
  localparam int unsigned MaskW = 4;

  // Master index; also the value stored per outstanding read in the owner FIFO.
  typedef enum logic {
    MstCpu = 1'b0,
    MstDma = 1'b1
  } master_e;

  // One master's request fields, forwarded unchanged when that master is selected.
  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] address;
    logic             read;
    logic             write;
    logic [DataW-1:0] writedata;
    logic [MaskW-1:0] writedatamask;
  } mem_req_t;

  function automatic master_e other_master(master_e m);
    return (m == MstCpu) ? MstDma : MstCpu;
  endfunction

endpackage

// File: rtl/mem_arbiter2_owner_fifo.sv
// Owner FIFO: 1-bit-wide, Depth-deep synchronous FIFO recording which master issued
// each outstanding read. Supports simultaneous push and pop, including push at full
// when a pop happens in the same cycle.
// Ports:
//   clock_i  - clock
//   rst_n    - asynchronous active-low reset (empties the FIFO)
//   push_i   - write data_i at the tail
//   data_i   - owner bit to store
//   pop_i    - discard the head entry
//   data_o   - owner bit at the head (valid when ~empty_o)
//   full_o   - Depth entries held
//   empty_o  - no entries held
module mem_arbiter2_owner_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clock_i,
  input  logic rst_n,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_eff, pop_eff;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push at full is only legal alongside a pop; an underflowing pop is ignored.
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointer increment wraps naturally.
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_eff) wr_ptr_d = wr_ptr_q + PtrW'(1);
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) mem_q[wr_ptr_q] <= data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master arbiter for the single pipelined memory port feeding sram16_ctrl.
// Master 0 is the CPU port, master 1 a DMA-style master. The downstream port is granted
// round-robin (or with fixed master-0 priority when PRIO0=1), the owner of every accepted
// read is queued, and tagged read responses are steered back to that owner in order.
// Ports:
//   clock_i, rst_n              - clock, asynchronous active-low reset
//   mN_*_i                      - master N request: id, address, read, write, data, mask
//   mN_waitrequest_o            - stall to master N
//   mN_readdata_o               - broadcast copy of mem_readdata_i
//   mN_readdataid_o             - response tag for master N, 0 = none this cycle
//   mem_waitrequest_i           - downstream stall
//   mem_*_o                     - downstream request (selected master's fields)
//   mem_readdata_i/readdataid_i - downstream response, id 0 = none
//   err_orphan_o                - sticky: a response arrived with no read outstanding
module mem_arbiter2
  import mem_arbiter2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter bit          PRIO0 = 1'b0
) (
  input  logic             clock_i,
  input  logic             rst_n,

  output logic             m0_waitrequest_o,
  input  logic [IdW-1:0]   m0_id_i,
  input  logic [AddrW-1:0] m0_address_i,
  input  logic             m0_read_i,
  input  logic             m0_write_i,
  input  logic [DataW-1:0] m0_writedata_i,
  input  logic [MaskW-1:0] m0_writedatamask_i,
  output logic [DataW-1:0] m0_readdata_o,
  output logic [IdW-1:0]   m0_readdataid_o,

  output logic             m1_waitrequest_o,
  input  logic [IdW-1:0]   m1_id_i,
  input  logic [AddrW-1:0] m1_address_i,
  input  logic             m1_read_i,
  input  logic             m1_write_i,
  input  logic [DataW-1:0] m1_writedata_i,
  input  logic [MaskW-1:0] m1_writedatamask_i,
  output logic [DataW-1:0] m1_readdata_o,
  output logic [IdW-1:0]   m1_readdataid_o,

  input  logic             mem_waitrequest_i,
  output logic [IdW-1:0]   mem_id_o,
  output logic [AddrW-1:0] mem_address_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [DataW-1:0] mem_writedata_o,
  output logic [MaskW-1:0] mem_writedatamask_o,
  input  logic [DataW-1:0] mem_readdata_i,
  input  logic [IdW-1:0]   mem_readdataid_i,

  output logic             err_orphan_o
);

  mem_req_t req0, req1, sel_req;
  logic     rq0, rq1, sel_rq;
  master_e  sel;
  master_e  grant_q, grant_d;
  master_e  last_q, last_d;
  logic     hold_q, hold_d;
  logic     err_q, err_d;

  logic     resp_valid, pop, push, orphan, read_blocked, accept;
  logic     fifo_head, fifo_full, fifo_empty;
  master_e  head_owner;

  assign req0 = '{id: m0_id_i, address: m0_address_i, read: m0_read_i, write: m0_write_i,
                  writedata: m0_writedata_i, writedatamask: m0_writedatamask_i};
  assign req1 = '{id: m1_id_i, address: m1_address_i, read: m1_read_i, write: m1_write_i,
                  writedata: m1_writedata_i, writedatamask: m1_writedatamask_i};

  assign rq0 = m0_read_i | m0_write_i;
  assign rq1 = m1_read_i | m1_write_i;

  // Arbitration. A master left waiting keeps the port until its request is accepted,
  // so the fields seen downstream never change under a stall.
  always_comb begin
    sel = grant_q;
    if (hold_q && ((grant_q == MstCpu) ? rq0 : rq1)) begin
      sel = grant_q;
    end else if (rq0 && !rq1) begin
      sel = MstCpu;
    end else if (rq1 && !rq0) begin
      sel = MstDma;
    end else if (rq0 && rq1) begin
      sel = PRIO0 ? MstCpu : other_master(last_q);
    end
  end

  assign sel_req = (sel == MstDma) ? req1 : req0;
  assign sel_rq  = sel_req.read | sel_req.write;

  // Response handling: a response with nothing outstanding is an orphan and is dropped.
  assign resp_valid = (mem_readdataid_i != '0);
  assign pop        = resp_valid & ~fifo_empty;
  assign orphan     = resp_valid & fifo_empty;
  assign head_owner = fifo_head ? MstDma : MstCpu;

  // A read is held back only when the FIFO is full and no slot frees up this cycle.
  assign read_blocked = fifo_full & sel_req.read & ~pop;
  assign accept       = sel_rq & ~mem_waitrequest_i & ~read_blocked;
  assign push         = accept & sel_req.read;

  // Downstream request.
  assign mem_id_o            = sel_req.id;
  assign mem_address_o       = sel_req.address;
  assign mem_read_o          = sel_req.read & ~read_blocked;
  assign mem_write_o         = sel_req.write;
  assign mem_writedata_o     = sel_req.writedata;
  assign mem_writedatamask_o = sel_req.writedatamask;

  // Waitrequest: the selected master follows downstream; a requesting loser is stalled;
  // an idle loser just sees mem_waitrequest_i.
  assign m0_waitrequest_o = (sel == MstCpu) ? (mem_waitrequest_i | read_blocked)
                                            : (rq0 | mem_waitrequest_i);
  assign m1_waitrequest_o = (sel == MstDma) ? (mem_waitrequest_i | read_blocked)
                                            : (rq1 | mem_waitrequest_i);

  // Response routing.
  assign m0_readdata_o   = mem_readdata_i;
  assign m1_readdata_o   = mem_readdata_i;
  assign m0_readdataid_o = (pop && head_owner == MstCpu) ? mem_readdataid_i : '0;
  assign m1_readdataid_o = (pop && head_owner == MstDma) ? mem_readdataid_i : '0;

  assign err_orphan_o = err_q;

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    hold_d  = sel_rq & ~accept;
    err_d   = err_q | orphan;
    if (rq0 || rq1) grant_d = sel;
    if (accept)     last_d  = sel;
  end

  always_ff @(posedge clock_i or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= MstCpu;
      last_q  <= MstDma;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  mem_arbiter2_owner_fifo #(
    .Depth (DEPTH)
  ) u_owner_fifo (
    .clock_i (clock_i),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (sel == MstDma),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_mem_arbiter2.sv
// Self-checking bench for mem_arbiter2: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model of the arbiter.
module tb_mem_arbiter2;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Master-side stimulus, index = master number.
  logic [1:0]  id    [2];
  logic [29:0] addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic [3:0]  mask  [2];
  logic        mem_wait;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rid;

  // Round-robin instance outputs.
  logic        rr_wait  [2];
  logic [31:0] rr_rdata [2];
  logic [1:0]  rr_rid   [2];
  logic [1:0]  rr_mem_id;
  logic [29:0] rr_mem_addr;
  logic        rr_mem_rd, rr_mem_wr, rr_err;
  logic [31:0] rr_mem_wdata;
  logic [3:0]  rr_mem_mask;

  // Fixed-priority instance outputs.
  logic        pr_wait  [2];
  logic [31:0] pr_rdata [2];
  logic [1:0]  pr_rid   [2];
  logic [1:0]  pr_mem_id;
  logic [29:0] pr_mem_addr;
  logic        pr_mem_rd, pr_mem_wr, pr_err;
  logic [31:0] pr_mem_wdata;
  logic [3:0]  pr_mem_mask;

  mem_arbiter2 #(.DEPTH(DEPTH), .PRIO0(1'b0)) u_rr (
    .clock_i(clk), .rst_n(rst_n),
    .m0_waitrequest_o(rr_wait[0]), .m0_id_i(id[0]), .m0_address_i(addr[0]),
    .m0_read_i(rd[0]), .m0_write_i(wr[0]), .m0_writedata_i(wdata[0]),
    .m0_writedatamask_i(mask[0]), .m0_readdata_o(rr_rdata[0]), .m0_readdataid_o(rr_rid[0]),
    .m1_waitrequest_o(rr_wait[1]), .m1_id_i(id[1]), .m1_address_i(addr[1]),
    .m1_read_i(rd[1]), .m1_write_i(wr[1]), .m1_writedata_i(wdata[1]),
    .m1_writedatamask_i(mask[1]), .m1_readdata_o(rr_rdata[1]), .m1_readdataid_o(rr_rid[1]),
    .mem_waitrequest_i(mem_wait), .mem_id_o(rr_mem_id), .mem_address_o(rr_mem_addr),
    .mem_read_o(rr_mem_rd), .mem_write_o(rr_mem_wr), .mem_writedata_o(rr_mem_wdata),
    .mem_writedatamask_o(rr_mem_mask), .mem_readdata_i(mem_rdata),
    .mem_readdataid_i(mem_rid), .err_orphan_o(rr_err)
  );

  mem_arbiter2 #(.DEPTH(DEPTH), .PRIO0(1'b1)) u_pr (
    .clock_i(clk), .rst_n(rst_n),
    .m0_waitrequest_o(pr_wait[0]), .m0_id_i(id[0]), .m0_address_i(addr[0]),
    .m0_read_i(rd[0]), .m0_write_i(wr[0]), .m0_writedata_i(wdata[0]),
    .m0_writedatamask_i(mask[0]), .m0_readdata_o(pr_rdata[0]), .m0_readdataid_o(pr_rid[0]),
    .m1_waitrequest_o(pr_wait[1]), .m1_id_i(id[1]), .m1_address_i(addr[1]),
    .m1_read_i(rd[1]), .m1_write_i(wr[1]), .m1_writedata_i(wdata[1]),
    .m1_writedatamask_i(mask[1]), .m1_readdata_o(pr_rdata[1]), .m1_readdataid_o(pr_rid[1]),
    .mem_waitrequest_i(mem_wait), .mem_id_o(pr_mem_id), .mem_address_o(pr_mem_addr),
    .mem_read_o(pr_mem_rd), .mem_write_o(pr_mem_wr), .mem_writedata_o(pr_mem_wdata),
    .mem_writedatamask_o(pr_mem_mask), .mem_readdata_i(mem_rdata),
    .mem_readdataid_i(mem_rid), .err_orphan_o(pr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model of the round-robin instance.
  int         own_q [$];   // owner of each outstanding read, oldest first
  logic [1:0] pend_q [$];  // ids the fake memory still owes, oldest first
  int         last_m, grant_m, sel_m;
  bit         hold_m, err_m, acc_m, pop_m, orph_m;

  task automatic model_reset();
    own_q.delete();
    pend_q.delete();
    last_m  = 1;
    grant_m = 0;
    hold_m  = 1'b0;
    err_m   = 1'b0;
  endtask

  task automatic idle();
    rd[0] = 1'b0; wr[0] = 1'b0;
    rd[1] = 1'b0; wr[1] = 1'b0;
    mem_wait = 1'b0;
    mem_rid  = 2'd0;
  endtask

  // Called just after a negedge with inputs applied: predict and compare this cycle.
  task automatic settle();
    bit rq0, rq1, blocked;
    logic [1:0] exp_rid;
    logic exp_wait;
    #1;
    rq0 = rd[0] | wr[0];
    rq1 = rd[1] | wr[1];
    if (hold_m && (grant_m == 0 ? rq0 : rq1)) sel_m = grant_m;
    else if (rq0 && rq1)                      sel_m = 1 - last_m;
    else if (rq0)                             sel_m = 0;
    else if (rq1)                             sel_m = 1;
    else                                      sel_m = grant_m;
    pop_m   = (mem_rid != 2'd0) && (own_q.size() > 0);
    orph_m  = (mem_rid != 2'd0) && (own_q.size() == 0);
    blocked = (own_q.size() == int'(DEPTH)) && rd[sel_m] && !pop_m;
    acc_m   = (rd[sel_m] | wr[sel_m]) && !mem_wait && !blocked;
    check("mem_read",  32'(rr_mem_rd), 32'(rd[sel_m] && !blocked));
    check("mem_write", 32'(rr_mem_wr), 32'(wr[sel_m]));
    check("mem_addr",  32'(rr_mem_addr), 32'(addr[sel_m]));
    check("mem_id",    32'(rr_mem_id), 32'(id[sel_m]));
    check("mem_wdata", rr_mem_wdata, wdata[sel_m]);
    check("mem_mask",  32'(rr_mem_mask), 32'(mask[sel_m]));
    check("err_orphan", 32'(rr_err), 32'(err_m));
    for (int n = 0; n < 2; n++) begin
      exp_wait = (n == sel_m) ? (mem_wait | blocked) : ((rd[n] | wr[n]) ? 1'b1 : mem_wait);
      exp_rid  = (pop_m && own_q[0] == n) ? mem_rid : 2'd0;
      check($sformatf("wait%0d", n),  32'(rr_wait[n]), 32'(exp_wait));
      check($sformatf("rid%0d", n),   32'(rr_rid[n]), 32'(exp_rid));
      check($sformatf("rdata%0d", n), rr_rdata[n], mem_rdata);
    end
  endtask

  // Clock the model through the posedge and return at the following negedge.
  task automatic advance();
    @(posedge clk);
    if (pop_m) begin
      void'(own_q.pop_front());
      void'(pend_q.pop_front());
    end
    if (acc_m && rd[sel_m]) begin
      own_q.push_back(sel_m);
      pend_q.push_back(id[sel_m]);
    end
    if (acc_m) last_m = sel_m;
    if (rd[0] | wr[0] | rd[1] | wr[1]) grant_m = sel_m;
    hold_m = (rd[sel_m] | wr[sel_m]) && !acc_m;
    if (orph_m) err_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int n, input bit is_rd, input logic [1:0] i,
                         input logic [29:0] a);
    rd[n] = is_rd;
    wr[n] = !is_rd;
    id[n] = i;
    addr[n] = a;
    wdata[n] = $urandom;
    mask[n] = 4'($urandom);
  endtask

  bit busy [2];
  int owners [4] = '{0, 1, 0, 1};

  initial begin
    for (int n = 0; n < 2; n++) begin
      id[n] = '0; addr[n] = '0; wdata[n] = '0; mask[n] = '0;
    end
    mem_rdata = '0;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Lone read by master 0, response on the next cycle.
    set_req(0, 1'b1, 2'd1, 30'h10);
    settle();
    check("d1_addr", 32'(rr_mem_addr), 32'h10);
    check("d1_read", 32'(rr_mem_rd), 32'd1);
    advance();
    rd[0] = 1'b0;
    mem_rid = 2'd1;
    mem_rdata = 32'hDEADBEEF;
    settle();
    check("d1_rid0", 32'(rr_rid[0]), 32'd1);
    check("d1_rid1", 32'(rr_rid[1]), 32'd0);
    check("d1_rdata0", rr_rdata[0], 32'hDEADBEEF);
    advance();
    mem_rid = 2'd0;

    // Both masters writing continuously: round-robin alternates, priority keeps master 0.
    set_req(0, 1'b0, 2'd0, 30'h100);
    set_req(1, 1'b0, 2'd0, 30'h200);
    for (int i = 0; i < 6; i++) begin
      settle();
      // Master 0 was served last, so master 1 wins first.
      check("rr_alt_w1", 32'(rr_wait[1]), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_alt_w0", 32'(rr_wait[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("prio_w0", 32'(pr_wait[0]), 32'd0);
      check("prio_w1", 32'(pr_wait[1]), 32'd1);
      advance();
    end
    wr[0] = 1'b0;
    settle();
    check("prio_m1_alone", 32'(pr_wait[1]), 32'd0);
    check("prio_m1_addr", 32'(pr_mem_addr), 32'h200);
    advance();

    // Master 1 read stalled downstream keeps the port while master 0 starts requesting.
    idle();
    set_req(1, 1'b0, 2'd0, 30'h300);
    settle();
    advance();
    set_req(1, 1'b1, 2'd2, 30'h22);
    mem_wait = 1'b1;
    settle();
    advance();
    set_req(0, 1'b0, 2'd0, 30'h33);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("hold_w0", 32'(rr_wait[0]), 32'd1);
      check("hold_addr", 32'(rr_mem_addr), 32'h22);
      advance();
    end
    mem_wait = 1'b0;
    settle();
    check("hold_acc_w1", 32'(rr_wait[1]), 32'd0);
    check("hold_acc_w0", 32'(rr_wait[0]), 32'd1);
    check("hold_acc_rd", 32'(rr_mem_rd), 32'd1);
    advance();
    rd[1] = 1'b0;
    settle();
    advance();
    wr[0] = 1'b0;
    mem_rid = 2'd2;
    settle();
    check("hold_rid1", 32'(rr_rid[1]), 32'd2);
    check("hold_rid0", 32'(rr_rid[0]), 32'd0);
    advance();

    // Fill the owner FIFO, then exercise full-stall and push+pop at full.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      set_req(owners[i], 1'b1, (owners[i] == 0) ? 2'd1 : 2'd3, 30'(i));
      settle();
      advance();
    end
    idle();
    set_req(1, 1'b0, 2'd0, 30'h44);
    settle();
    check("full_wr_w1", 32'(rr_wait[1]), 32'd0);
    check("full_wr_mw", 32'(rr_mem_wr), 32'd1);
    advance();
    idle();
    set_req(0, 1'b1, 2'd1, 30'h55);
    settle();
    check("full_stall_w0", 32'(rr_wait[0]), 32'd1);
    check("full_stall_rd", 32'(rr_mem_rd), 32'd0);
    advance();
    mem_rid = 2'd1;
    settle();
    check("full_pp_w0", 32'(rr_wait[0]), 32'd0);
    check("full_pp_rd", 32'(rr_mem_rd), 32'd1);
    check("full_pp_rid0", 32'(rr_rid[0]), 32'd1);
    advance();
    idle();
    set_req(1, 1'b1, 2'd3, 30'h66);
    settle();
    check("still_full_w1", 32'(rr_wait[1]), 32'd1);
    advance();
    mem_rid = 2'd3;
    settle();
    check("full_pp2_w1", 32'(rr_wait[1]), 32'd0);
    check("full_pp2_rid1", 32'(rr_rid[1]), 32'd3);
    advance();
    idle();
    for (int i = 0; i < 4; i++) begin
      mem_rid = (owners[i] == 0) ? 2'd1 : 2'd3;
      settle();
      check("drain_owner", 32'(rr_rid[owners[i]]), 32'(mem_rid));
      check("drain_other", 32'(rr_rid[1 - owners[i]]), 32'd0);
      advance();
    end

    // Orphan response with an empty FIFO.
    mem_rid = 2'd2;
    settle();
    check("orph_rid0", 32'(rr_rid[0]), 32'd0);
    check("orph_rid1", 32'(rr_rid[1]), 32'd0);
    advance();
    mem_rid = 2'd0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("orph_sticky", 32'(rr_err), 32'd1);
      advance();
    end

    // Asynchronous reset with two reads outstanding.
    do_reset();
    set_req(0, 1'b1, 2'd1, 30'h77);
    settle();
    advance();
    idle();
    set_req(1, 1'b1, 2'd2, 30'h78);
    settle();
    advance();
    idle();
    #2;
    rst_n = 1'b0;
    mem_rid = 2'd1;
    #1;
    check("arst_rid0", 32'(rr_rid[0]), 32'd0);
    check("arst_rid1", 32'(rr_rid[1]), 32'd0);
    check("arst_err", 32'(rr_err), 32'd0);
    do_reset();

    // Randomized traffic against the model.
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!busy[n] && $urandom_range(0, 2) != 0) begin
          busy[n] = 1'b1;
          set_req(n, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)), 30'($urandom));
        end
      end
      mem_wait  = ($urandom_range(0, 3) == 0);
      mem_rid   = (pend_q.size() > 0 && $urandom_range(0, 1) == 1) ? pend_q[0] : 2'd0;
      mem_rdata = $urandom;
      settle();
      advance();
      for (int n = 0; n < 2; n++) begin
        if (acc_m && sel_m == n) begin
          busy[n] = 1'b0;
          rd[n] = 1'b0;
          wr[n] = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
